// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side AXI4 read-channel arbitration logic.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam logic [3:0] ARID_ICACHE = 4'd0;
  localparam logic [3:0] ARID_DCACHE = 4'd1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester grant picker. grant[0] = icache, grant[1] = dcache (one-hot).
// Macro CACHE_ARB_RR_EN selects round-robin on contention; otherwise the
// dcache always wins on contention.
module arb_pick2 (
  input  logic       req_i,
  input  logic       req_d,
  input  logic       last_d,   // 1 = dcache was granted last
  output logic [1:0] grant
);

`ifdef CACHE_ARB_RR_EN
  // Round-robin: on contention the side not granted last wins.
  always_comb begin
    grant = 2'b00;
    if (req_i && req_d) grant = last_d ? 2'b01 : 2'b10;
    else if (req_d)     grant = 2'b10;
    else if (req_i)     grant = 2'b01;
  end
`else
  logic unused_last;
  assign unused_last = last_d;

  // Fixed priority: dcache ahead of icache.
  always_comb begin
    grant = 2'b00;
    if (req_d)      grant = 2'b10;
    else if (req_i) grant = 2'b01;
  end
`endif

endmodule

// File: rtl/cache_bus_arbiter.sv
// Read-channel arbiter: icache refill and dcache refill/uncached read share
// one AXI4 AR/R channel, one transaction outstanding at a time. A pipeline
// flush turns an in-flight icache burst into a drained, discarded burst.
// Arbitration policy selected by macro CACHE_ARB_RR_EN (see arb_pick2).
//
// Handshakes: an AXI transfer happens on a cycle where valid && ready are both
// high; arvalid, once raised, stays high with stable araddr/arlen/arid until
// arready. Requester req is held until its ack pulse; ack fires in the AR
// handshake cycle. Beats are forwarded in the cycle rvalid && rready.
module cache_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              i_ack,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  output logic              d_rerr,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [1:0]        dbg_state
);

  localparam int PAD_W = 8 - LEN_W;

  arb_state_e        state_q, state_d;
  logic              arvalid_d;
  logic [ADDR_W-1:0] araddr_d;
  logic [7:0]        arlen_d;
  logic [3:0]        arid_d;
  logic              discard_q, discard_d;
  logic              err_q, err_d;
  logic              last_q, last_d;
  logic [1:0]        grant;
  logic              own_d;
  logic              beat;
  logic              unused_resp;

  assign unused_resp = rresp[0];
  assign own_d       = (arid == ARID_DCACHE);

  // A flush at the arbitration point removes the icache from contention.
  arb_pick2 u_pick (
    .req_i  (i_req & ~flush),
    .req_d  (d_req),
    .last_d (last_q),
    .grant  (grant)
  );

  // State and channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      arvalid   <= 1'b0;
      araddr    <= '0;
      arlen     <= '0;
      arid      <= ARID_ICACHE;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid   <= arvalid_d;
      araddr    <= araddr_d;
      arlen     <= arlen_d;
      arid      <= arid_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      last_q    <= last_d;
    end
  end

  // Next-state: grant in IDLE, hold AR until handshake, run beats to rlast.
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid;
    araddr_d  = araddr;
    arlen_d   = arlen;
    arid_d    = arid;
    discard_d = discard_q;
    err_d     = err_q;
    last_d    = last_q;
    case (state_q)
      ARB_IDLE: begin
        discard_d = 1'b0;
        err_d     = 1'b0;
        if (grant[1]) begin
          state_d   = ARB_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = d_addr;
          arlen_d   = {{PAD_W{1'b0}}, d_len};
          arid_d    = ARID_DCACHE;
          last_d    = 1'b1;
        end else if (grant[0]) begin
          state_d   = ARB_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = i_addr;
          arlen_d   = {{PAD_W{1'b0}}, i_len};
          arid_d    = ARID_ICACHE;
          last_d    = 1'b0;
        end
      end
      ARB_ADDR: begin
        if (flush && !own_d) discard_d = 1'b1;
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (flush && !own_d) discard_d = 1'b1;
        if (rvalid) begin
          err_d = err_q | rresp[1];
          if (rlast) begin
            state_d   = ARB_IDLE;
            discard_d = 1'b0;
            err_d     = 1'b0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign beat      = (state_q == ARB_DATA) & rvalid;
  assign rready    = (state_q == ARB_DATA);
  assign arsize    = AXI_SIZE_WORD;
  assign arburst   = AXI_BURST_INCR;
  assign dbg_state = state_q;

  assign i_ack    = arvalid & arready & ~own_d & ~discard_q;
  assign d_ack    = arvalid & arready & own_d;
  assign i_rvalid = beat & ~own_d & ~discard_q;
  assign i_rlast  = i_rvalid & rlast;
  assign i_rdata  = rdata;
  assign d_rvalid = beat & own_d;
  assign d_rlast  = d_rvalid & rlast;
  assign d_rdata  = rdata;
  assign d_rerr   = d_rlast & (err_q | rresp[1]);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter (adapts to CACHE_ARB_RR_EN).
module tb_cache_bus_arbiter;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [3:0]  i_len, d_len;
  logic        i_ack, i_rvalid, i_rlast;
  logic [31:0] i_rdata;
  logic        d_ack, d_rvalid, d_rlast, d_rerr;
  logic [31:0] d_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  cache_bus_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_ack(i_ack),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_ack(d_ack),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rerr(d_rerr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .dbg_state(dbg_state)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One single-beat transfer starting in an IDLE cycle with requests applied.
  task automatic xfer(input logic exp_d, input logic [31:0] data, input logic [1:0] resp);
    #1;
    chk("x_idle_st", dbg_state, ARB_IDLE);
    chk("x_idle_arvalid", arvalid, 1'b0);
    cyc(); arready = 1'b1; #1;
    chk("x_arvalid", arvalid, 1'b1);
    chk("x_arid", arid, {3'b000, exp_d});
    chk("x_araddr", araddr, exp_d ? d_addr : i_addr);
    chk("x_i_ack", i_ack, !exp_d);
    chk("x_d_ack", d_ack, exp_d);
    cyc();
    arready = 1'b0;
    if (exp_d) d_req = 1'b0; else i_req = 1'b0;
    rvalid = 1'b1; rlast = 1'b1; rdata = data; rresp = resp; #1;
    chk("x_rready", rready, 1'b1);
    chk("x_i_rvalid", i_rvalid, !exp_d);
    chk("x_d_rvalid", d_rvalid, exp_d);
    chk("x_i_rlast", i_rlast, !exp_d);
    chk("x_d_rlast", d_rlast, exp_d);
    chk("x_rdata", exp_d ? d_rdata : i_rdata, data);
    chk("x_d_rerr", d_rerr, exp_d & resp[1]);
    cyc(); rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; #1;
    chk("x_end_st", dbg_state, ARB_IDLE);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    i_req = 1'b0; i_addr = '0; i_len = '0;
    d_req = 1'b0; d_addr = '0; d_len = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    // reset state
    repeat (3) cyc();
    #1;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_arlen", arlen, 8'h0);
    chk("rst_arid", arid, 4'h0);
    chk("rst_state", dbg_state, ARB_IDLE);
    chk("rst_acks", {i_ack, d_ack, i_rvalid, d_rvalid, d_rerr}, 5'b0);
    cyc(); rst = 1'b0;

    // single icache burst, arready two cycles late
    cyc(); i_req = 1'b1; i_addr = 32'h1FC0_0000; i_len = 4'd3; #1;
    chk("t1_idle_arvalid", arvalid, 1'b0);
    cyc(); #1;
    chk("t1_arvalid1", arvalid, 1'b1);
    chk("t1_arid", arid, 4'd0);
    chk("t1_arlen", arlen, 8'd3);
    chk("t1_araddr", araddr, 32'h1FC0_0000);
    chk("t1_arsize", arsize, 3'b010);
    chk("t1_arburst", arburst, 2'b01);
    chk("t1_noack1", i_ack, 1'b0);
    cyc(); #1;
    chk("t1_arvalid2", arvalid, 1'b1);
    chk("t1_noack2", i_ack, 1'b0);
    cyc(); arready = 1'b1; #1;
    chk("t1_arvalid3", arvalid, 1'b1);
    chk("t1_i_ack", i_ack, 1'b1);
    chk("t1_d_ack", d_ack, 1'b0);
    cyc(); arready = 1'b0; i_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) cyc();
      rvalid = 1'b1; rdata = 32'hA000_0000 + b; rlast = (b == 3); #1;
      chk("t1_i_rvalid", i_rvalid, 1'b1);
      chk("t1_i_rdata", i_rdata, 32'hA000_0000 + b);
      chk("t1_i_rlast", i_rlast, (b == 3));
      chk("t1_d_rvalid", d_rvalid, 1'b0);
      chk("t1_ack_once", i_ack, 1'b0);
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0; #1;
    chk("t1_idle", dbg_state, ARB_IDLE);
    chk("t1_rready0", rready, 1'b0);
    chk("t1_arvalid0", arvalid, 1'b0);

    // four back-to-back contended rounds
    i_req = 1'b1; d_req = 1'b1;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; i_len = 4'd0; d_len = 4'd0;
    for (int r = 0; r < 4; r++) begin
      logic exp_d;
`ifdef CACHE_ARB_RR_EN
      exp_d = (r % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      xfer(exp_d, 32'hB000_0000 + r, 2'b00);
      if (exp_d) d_req = 1'b1; else i_req = 1'b1;
    end
    // simultaneous: dcache first, then the waiting icache
    xfer(1'b1, 32'hC000_0001, 2'b00);
    xfer(1'b0, 32'hC000_0002, 2'b00);

    // flush in the same cycle as i_req: icache not eligible
    i_req = 1'b1; i_addr = 32'h0000_0300; flush = 1'b1;
    cyc(); #1;
    chk("t3_flush_idle", dbg_state, ARB_IDLE);
    chk("t3_flush_noar", arvalid, 1'b0);
    flush = 1'b0;
    xfer(1'b0, 32'hC000_0003, 2'b00);

    // flush while icache is in ADDR: ack suppressed, beat discarded
    i_req = 1'b1; i_addr = 32'h0000_0400; i_len = 4'd0;
    cyc(); flush = 1'b1; #1;
    chk("t4_arvalid", arvalid, 1'b1);
    chk("t4_noack0", i_ack, 1'b0);
    cyc(); flush = 1'b0; arready = 1'b1; #1;
    chk("t4_arvalid_held", arvalid, 1'b1);
    chk("t4_ack_supp", i_ack, 1'b0);
    cyc(); arready = 1'b0; i_req = 1'b0; rvalid = 1'b1; rlast = 1'b1; #1;
    chk("t4_rready", rready, 1'b1);
    chk("t4_drop", {i_rvalid, i_rlast}, 2'b00);
    cyc(); rvalid = 1'b0; rlast = 1'b0; #1;
    chk("t4_idle", dbg_state, ARB_IDLE);

    // flush at icache beat 2 of 8; a dcache request waits for rlast
    i_req = 1'b1; i_addr = 32'h0000_0500; i_len = 4'd7;
    cyc(); arready = 1'b1; #1;
    chk("t5_i_ack", i_ack, 1'b1);
    chk("t5_arlen", arlen, 8'd7);
    cyc(); arready = 1'b0; i_req = 1'b0; rvalid = 1'b1; rdata = 32'hD000_0001; #1;
    chk("t5_beat1", i_rvalid, 1'b1);
    cyc(); rdata = 32'hD000_0002; #1;
    chk("t5_beat2", i_rvalid, 1'b1);
    chk("t5_beat2_data", i_rdata, 32'hD000_0002);
    cyc(); rvalid = 1'b0; flush = 1'b1;
    d_req = 1'b1; d_addr = 32'h0000_0600; d_len = 4'd3; #1;
    chk("t5_flush_gap", i_rvalid, 1'b0);
    chk("t5_flush_rready", rready, 1'b1);
    cyc(); flush = 1'b0;
    for (int b = 3; b <= 8; b++) begin
      if (b > 3) cyc();
      rvalid = 1'b1; rlast = (b == 8); rdata = 32'hD000_0000 + b; #1;
      chk("t5_drain_rready", rready, 1'b1);
      chk("t5_drain_i", {i_rvalid, i_rlast}, 2'b00);
      chk("t5_drain_d", d_rvalid, 1'b0);
      chk("t5_drain_noar", arvalid, 1'b0);
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0; #1;
    chk("t5_idle", dbg_state, ARB_IDLE);
    chk("t5_idle_noar", arvalid, 1'b0);

    // dcache burst under flush, SLVERR on beat 1
    cyc(); flush = 1'b1; #1;
    chk("t6_arvalid", arvalid, 1'b1);
    chk("t6_arid", arid, 4'd1);
    chk("t6_arlen", arlen, 8'd3);
    cyc(); arready = 1'b1; #1;
    chk("t6_d_ack", d_ack, 1'b1);
    cyc(); arready = 1'b0; d_req = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      if (b > 1) cyc();
      flush = b[0]; rvalid = 1'b1; rlast = (b == 4);
      rresp = (b == 1) ? 2'b10 : 2'b00; rdata = 32'hE000_0000 + b; #1;
      chk("t6_d_rvalid", d_rvalid, 1'b1);
      chk("t6_d_rdata", d_rdata, 32'hE000_0000 + b);
      chk("t6_d_rlast", d_rlast, (b == 4));
      chk("t6_d_rerr", d_rerr, (b == 4));
      chk("t6_i_rvalid", i_rvalid, 1'b0);
    end
    cyc(); rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; flush = 1'b0; #1;
    chk("t6_idle", dbg_state, ARB_IDLE);
    chk("t6_rerr_idle", d_rerr, 1'b0);

    // error flag cleared between bursts; SLVERR on the last beat; icache back to normal
    d_req = 1'b1; d_addr = 32'h0000_0700; d_len = 4'd0;
    xfer(1'b1, 32'hF000_0001, 2'b00);
    d_req = 1'b1;
    xfer(1'b1, 32'hF000_0002, 2'b10);
    i_req = 1'b1; i_addr = 32'h0000_0780; i_len = 4'd0;
    xfer(1'b0, 32'hF000_0003, 2'b00);

    // reset mid-DATA
    i_req = 1'b1; i_addr = 32'h0000_0800; i_len = 4'd3;
    cyc(); arready = 1'b1; #1;
    chk("t8_i_ack", i_ack, 1'b1);
    cyc(); arready = 1'b0; i_req = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; #1;
    chk("t8_beat", i_rvalid, 1'b1);
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0; rvalid = 1'b0; #1;
    chk("t8_arvalid", arvalid, 1'b0);
    chk("t8_rready", rready, 1'b0);
    chk("t8_state", dbg_state, ARB_IDLE);
    chk("t8_araddr", araddr, 32'h0);
    chk("t8_i_rvalid", i_rvalid, 1'b0);
    d_req = 1'b1; d_addr = 32'h0000_0900; d_len = 4'd0;
    xfer(1'b1, 32'h5555_AAAA, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
